// File: rtl/uart_rx_pkg.sv
// Shared types for the UART RX majority-vote sampler: vote-mode codes, vote-count decode, FSM states.
// No logic or latency of its own; no backpressure.
package uart_rx_pkg;

   localparam logic [1:0] VOTE_1 = 2'd0;
   localparam logic [1:0] VOTE_3 = 2'd1;
   localparam logic [1:0] VOTE_5 = 2'd2;
   localparam logic [1:0] VOTE_7 = 2'd3;

   localparam int CNT_W = 3;

   typedef logic [CNT_W-1:0] vote_cnt_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_COLLECT,
      ST_HOLD
   } rx_state_t;

   function automatic vote_cnt_t votes_of(input logic [1:0] sel);
      case (sel)
         VOTE_1:  return vote_cnt_t'(1);
         VOTE_3:  return vote_cnt_t'(3);
         VOTE_5:  return vote_cnt_t'(5);
         default: return vote_cnt_t'(7);
      endcase
   endfunction

   // (V-1)/2 for odd V is just the upper two bits
   function automatic logic [1:0] half_of(input vote_cnt_t v);
      return v[2:1];
   endfunction

endpackage

// File: rtl/uart_rx_vote_sampler_if.sv
// Bundle between the RX edge counter (master) and the vote sampler (slave).
// Pure wiring, zero latency; no backpressure (one decision per bit, always accepted).
interface uart_rx_vote_sampler_if #(
   parameter int PRESCALE_W = 6
);
   logic                  enable;
   logic                  rx_in;
   logic [PRESCALE_W-1:0] prescale;
   logic [PRESCALE_W-1:0] edge_cnt;
   logic [1:0]            vote_sel;
   logic                  rx_sync;
   logic                  sampled;
   logic                  sample_valid;
   logic                  noise_err;
   logic                  cfg_err;

   modport master (
      output enable, rx_in, prescale, edge_cnt, vote_sel,
      input  rx_sync, sampled, sample_valid, noise_err, cfg_err
   );

   modport slave (
      input  enable, rx_in, prescale, edge_cnt, vote_sel,
      output rx_sync, sampled, sample_valid, noise_err, cfg_err
   );
endinterface

// File: rtl/uart_rx_vote_sampler_rx_sync.sv
// Reset-to-idle (1) multi-flop synchroniser for the raw serial line; latency STAGES cycles.
// No backpressure: free-running every clock.
module rx_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
      end
   end

   assign q = sync_q[STAGES-1];
endmodule

// File: rtl/uart_rx_vote_sampler.sv
// Majority-vote bit sampler centred on mid-bit; decision registered one cycle after the last vote.
// No backpressure: one sample_valid pulse per bit that the consumer must take.
module uart_rx_vote_sampler
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE_W  = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   uart_rx_vote_sampler_if.slave bus
);
   typedef logic [PRESCALE_W-1:0] pos_t;

   logic rx_sync_w;

   rx_sync #(.STAGES(SYNC_STAGES)) u_rx_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.rx_in),
      .q   (rx_sync_w)
   );

   rx_state_t state;
   pos_t      win_lo_q;
   pos_t      win_hi_q;
   vote_cnt_t votes_q;
   logic [1:0] half_q;
   vote_cnt_t ones_cnt;
   vote_cnt_t tot_cnt;
   logic      sampled_q;
   logic      sample_valid_q;
   logic      noise_err_q;
   logic      cfg_err_q;

   vote_cnt_t             new_votes;
   logic [1:0]            new_half;
   pos_t                  new_c;
   pos_t                  half_ext;
   pos_t                  new_lo;
   logic [PRESCALE_W:0]   new_hi_w;
   logic                  new_bad;
   logic                  relatch;

   assign new_votes = votes_of(bus.vote_sel);
   assign new_half  = half_of(new_votes);
   assign new_c     = bus.prescale >> 1;
   assign half_ext  = pos_t'(new_half);
   assign new_lo    = new_c - half_ext;
   assign new_hi_w  = {1'b0, new_c} + {1'b0, half_ext};
   // c+h > prescale-1 rewritten without the subtraction so prescale=0 cannot wrap
   assign new_bad   = (new_c < half_ext) || (new_hi_w >= {1'b0, bus.prescale});
   assign relatch   = bus.enable && (bus.edge_cnt == '0);

   rx_state_t  eff_state;
   pos_t       eff_lo;
   pos_t       eff_hi;
   vote_cnt_t  eff_votes;
   logic [1:0] eff_half;
   vote_cnt_t  base_ones;
   vote_cnt_t  base_tot;

   // On a latch cycle the fresh configuration applies immediately, so a window
   // starting at edge_cnt 0 still gets its first vote.
   always_comb begin
      eff_state = state;
      eff_lo    = win_lo_q;
      eff_hi    = win_hi_q;
      eff_votes = votes_q;
      eff_half  = half_q;
      base_ones = ones_cnt;
      base_tot  = tot_cnt;
      if (relatch) begin
         eff_state = new_bad ? ST_IDLE : ST_WAIT;
         eff_lo    = new_lo;
         eff_hi    = new_hi_w[PRESCALE_W-1:0];
         eff_votes = new_votes;
         eff_half  = new_half;
         base_ones = '0;
         base_tot  = '0;
      end
   end

   logic      in_window;
   logic      vote_now;
   logic      last_vote;
   vote_cnt_t ones_next;
   vote_cnt_t tot_next;

   assign in_window = (bus.edge_cnt >= eff_lo) && (bus.edge_cnt <= eff_hi);
   assign vote_now  = ((eff_state == ST_WAIT) && (bus.edge_cnt == eff_lo)) ||
                      ((eff_state == ST_COLLECT) && in_window);
   assign last_vote = vote_now && (bus.edge_cnt == eff_hi);
   assign ones_next = base_ones + vote_cnt_t'(vote_now && rx_sync_w);
   assign tot_next  = base_tot + vote_cnt_t'(vote_now);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         win_lo_q       <= '0;
         win_hi_q       <= '0;
         votes_q        <= vote_cnt_t'(1);
         half_q         <= '0;
         ones_cnt       <= '0;
         tot_cnt        <= '0;
         sampled_q      <= 1'b1;
         sample_valid_q <= 1'b0;
         noise_err_q    <= 1'b0;
         cfg_err_q      <= 1'b0;
      end else begin
         sample_valid_q <= 1'b0;
         noise_err_q    <= 1'b0;
         if (!bus.enable) begin
            state    <= ST_IDLE;
            ones_cnt <= '0;
            tot_cnt  <= '0;
         end else begin
            if (relatch) begin
               win_lo_q  <= new_lo;
               win_hi_q  <= new_hi_w[PRESCALE_W-1:0];
               votes_q   <= new_votes;
               half_q    <= new_half;
               cfg_err_q <= new_bad;
            end
            ones_cnt <= ones_next;
            tot_cnt  <= tot_next;
            if (last_vote) begin
               state          <= ST_HOLD;
               sample_valid_q <= 1'b1;
               sampled_q      <= (ones_next > {1'b0, eff_half});
               noise_err_q    <= (ones_next != '0) && (ones_next != eff_votes);
            end else if (vote_now) begin
               state <= ST_COLLECT;
            end else begin
               state <= eff_state;
            end
         end
      end
   end

   assign bus.rx_sync      = rx_sync_w;
   assign bus.sampled      = sampled_q;
   assign bus.sample_valid = sample_valid_q;
   assign bus.noise_err    = noise_err_q;
   assign bus.cfg_err      = cfg_err_q;
endmodule

// File: tb/tb_uart_rx_vote_sampler.sv
// Bench for uart_rx_vote_sampler: directed scenarios plus randomized bits against a per-bit vote model.
module tb_uart_rx_vote_sampler;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   uart_rx_vote_sampler_if #(.PRESCALE_W(6)) bus ();

   uart_rx_vote_sampler #(.PRESCALE_W(6), .SYNC_STAGES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   bit   hist[$];
   bit   m_active;
   int   m_lo, m_hi, m_v, m_h, m_ones;
   logic m_valid, m_sampled, m_noise, m_cfg_err;

   task automatic model_reset();
      hist = {1'b1, 1'b1};
      m_active = 0; m_ones = 0;
      m_valid = 0; m_sampled = 1; m_noise = 0; m_cfg_err = 0;
   endtask

   // Drive one clock of inputs, advance the model, return #1 after the edge.
   task automatic tick(input bit en, input int ec, input bit rx, input int p, input int sel);
      int rxs;
      int c;
      bus.enable = en; bus.edge_cnt = 6'(ec); bus.rx_in = rx;
      bus.prescale = 6'(p); bus.vote_sel = 2'(sel);
      rxs = int'(hist[0]);
      m_valid = 0; m_noise = 0;
      if (!en) begin
         m_active = 0;
      end else begin
         if (ec == 0) begin
            m_v = 2 * sel + 1; m_h = (m_v - 1) / 2; c = p / 2;
            m_lo = c - m_h; m_hi = c + m_h;
            m_cfg_err = (c < m_h) || (m_hi > p - 1);
            m_active = !m_cfg_err; m_ones = 0;
         end
         if (m_active && ec >= m_lo && ec <= m_hi) begin
            m_ones += rxs;
            if (ec == m_hi) begin
               m_valid = 1; m_sampled = (m_ones > m_h);
               m_noise = (m_ones != 0) && (m_ones != m_v); m_active = 0;
            end
         end
      end
      @(posedge clk); #1;
      hist.push_back(rx);
      void'(hist.pop_front());
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.enable = 0; bus.rx_in = 0; bus.edge_cnt = 0; bus.prescale = 8; bus.vote_sel = 1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (bus.sampled !== 1'b1) $display("FAIL reset_sampled: got %b want 1", bus.sampled); else n_pass++;
      n_checks++; if (bus.sample_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.sample_valid); else n_pass++;
      n_checks++; if (bus.noise_err !== 1'b0) $display("FAIL reset_noise: got %b want 0", bus.noise_err); else n_pass++;
      n_checks++; if (bus.cfg_err !== 1'b0) $display("FAIL reset_cfg_err: got %b want 0", bus.cfg_err); else n_pass++;
      n_checks++; if (bus.rx_sync !== 1'b1) $display("FAIL reset_rx_sync: got %b want 1", bus.rx_sync); else n_pass++;
      bus.rx_in = 1; rst = 1'b0;
      model_reset();
      repeat (3) tick(0, 0, 1, 8, 1);
   endtask

   task automatic test_steady_3vote();
      for (int ec = 0; ec < 8; ec++) begin
         tick(1, ec, 1, 8, 1);
         n_checks++;
         if (bus.sample_valid !== (ec == 5)) $display("FAIL steady_valid ec=%0d: got %b want %b", ec, bus.sample_valid, ec == 5); else n_pass++;
         if (ec == 5) begin
            n_checks++; if (bus.sampled !== 1'b1) $display("FAIL steady_sampled: got %b want 1", bus.sampled); else n_pass++;
            n_checks++; if (bus.noise_err !== 1'b0) $display("FAIL steady_noise: got %b want 0", bus.noise_err); else n_pass++;
         end
      end
   endtask

   task automatic test_5vote_noise();
      logic [15:0] pat;
      pat = 16'hFFFF; pat[5] = 1'b0; pat[8] = 1'b0;   // rx_sync 1,0,1,1,0 at edge_cnt 6..10
      for (int ec = 0; ec < 16; ec++) begin
         tick(1, ec, pat[ec], 16, 2);
         n_checks++;
         if (bus.sample_valid !== (ec == 10)) $display("FAIL vote5_valid ec=%0d: got %b want %b", ec, bus.sample_valid, ec == 10); else n_pass++;
         if (ec == 10) begin
            n_checks++; if (bus.sampled !== 1'b1) $display("FAIL vote5_sampled: got %b want 1", bus.sampled); else n_pass++;
            n_checks++; if (bus.noise_err !== 1'b1) $display("FAIL vote5_noise: got %b want 1", bus.noise_err); else n_pass++;
         end
      end
   endtask

   task automatic test_cfg_err();
      n_checks++; if (bus.cfg_err !== 1'b0) $display("FAIL cfg_pre: got %b want 0", bus.cfg_err); else n_pass++;
      for (int ec = 0; ec < 4; ec++) begin
         tick(1, ec, 1, 4, 3);
         n_checks++; if (bus.cfg_err !== 1'b1) $display("FAIL cfg_err ec=%0d: got %b want 1", ec, bus.cfg_err); else n_pass++;
         n_checks++; if (bus.sample_valid !== 1'b0) $display("FAIL cfg_valid ec=%0d: got %b want 0", ec, bus.sample_valid); else n_pass++;
      end
      for (int ec = 0; ec < 8; ec++) begin
         tick(1, ec, 1, 8, 1);
         if (ec == 0) begin
            n_checks++; if (bus.cfg_err !== 1'b0) $display("FAIL cfg_clear: got %b want 0", bus.cfg_err); else n_pass++;
         end
         n_checks++;
         if (bus.sample_valid !== (ec == 5)) $display("FAIL cfg_recover_valid ec=%0d: got %b want %b", ec, bus.sample_valid, ec == 5); else n_pass++;
      end
   endtask

   task automatic test_enable_drop();
      for (int ec = 0; ec < 8; ec++) begin
         tick(ec < 4, ec, 0, 8, 1);
         n_checks++; if (bus.sample_valid !== 1'b0) $display("FAIL drop_valid ec=%0d: got %b want 0", ec, bus.sample_valid); else n_pass++;
         n_checks++; if (bus.sampled !== 1'b1) $display("FAIL drop_sampled ec=%0d: got %b want 1", ec, bus.sampled); else n_pass++;
      end
      for (int ec = 0; ec < 8; ec++) begin
         tick(1, ec, 0, 8, 1);
         n_checks++;
         if (bus.sample_valid !== (ec == 5)) $display("FAIL drop_next_valid ec=%0d: got %b want %b", ec, bus.sample_valid, ec == 5); else n_pass++;
         if (ec == 5) begin
            n_checks++; if (bus.sampled !== 1'b0) $display("FAIL drop_next_sampled: got %b want 0", bus.sampled); else n_pass++;
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int ec = 0; ec < 4; ec++) tick(1, ec, 1, 8, 1);
      n_checks++; if (bus.sampled !== 1'b0) $display("FAIL rstmid_pre_sampled: got %b want 0", bus.sampled); else n_pass++;
      bus.edge_cnt = 4; bus.rx_in = 0; rst = 1'b1;
      #1;
      n_checks++; if (bus.sampled !== 1'b1) $display("FAIL rstmid_sampled: got %b want 1", bus.sampled); else n_pass++;
      n_checks++; if (bus.sample_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", bus.sample_valid); else n_pass++;
      n_checks++; if (bus.rx_sync !== 1'b1) $display("FAIL rstmid_rx_sync: got %b want 1", bus.rx_sync); else n_pass++;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      tick(1, 5, 0, 8, 1);
      n_checks++; if (bus.rx_sync !== 1'b1) $display("FAIL rstmid_sync1: got %b want 1", bus.rx_sync); else n_pass++;
      tick(1, 6, 0, 8, 1);
      n_checks++; if (bus.rx_sync !== 1'b0) $display("FAIL rstmid_sync2: got %b want 0", bus.rx_sync); else n_pass++;
      tick(1, 7, 0, 8, 1);
      n_checks++; if (bus.sample_valid !== 1'b0) $display("FAIL rstmid_no_pulse: got %b want 0", bus.sample_valid); else n_pass++;
      n_checks++; if (bus.sampled !== 1'b1) $display("FAIL rstmid_hold: got %b want 1", bus.sampled); else n_pass++;
   endtask

   task automatic test_vote_sel_change();
      bit rx;
      for (int b = 0; b < 2; b++) begin
         for (int ec = 0; ec < 16; ec++) begin
            rx = 1'($urandom_range(0, 1));
            tick(1, ec, rx, 16, (b == 0 && ec < 2) ? 1 : 3);
            n_checks++;
            if (bus.sample_valid !== (ec == (b == 0 ? 9 : 11)))
               $display("FAIL selchg_valid bit=%0d ec=%0d: got %b want %b", b, ec, bus.sample_valid, ec == (b == 0 ? 9 : 11));
            else n_pass++;
            if (m_valid) begin
               n_checks++; if (bus.sampled !== m_sampled) $display("FAIL selchg_sampled bit=%0d: got %b want %b", b, bus.sampled, m_sampled); else n_pass++;
               n_checks++; if (bus.noise_err !== m_noise) $display("FAIL selchg_noise bit=%0d: got %b want %b", b, bus.noise_err, m_noise); else n_pass++;
            end
         end
      end
   endtask

   task automatic test_random();
      int  p, sel, len, drop, pd, sd;
      bit  level, rx, en;
      for (int b = 0; b < 40; b++) begin
         p = $urandom_range(3, 40); sel = $urandom_range(0, 3);
         len = p; drop = -1; level = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 4) == 0) len = $urandom_range(1, p);
         if ($urandom_range(0, 5) == 0) drop = $urandom_range(0, p - 1);
         for (int ec = 0; ec < len; ec++) begin
            rx = ($urandom_range(0, 3) == 0) ? ~level : level;
            en = !(drop >= 0 && ec >= drop);
            pd = p; sd = sel;
            if (ec > 0 && $urandom_range(0, 7) == 0) begin
               pd = $urandom_range(1, 63); sd = $urandom_range(0, 3);
            end
            tick(en, ec, rx, pd, sd);
            n_checks++; if (bus.sample_valid !== m_valid) $display("FAIL rand_valid b=%0d ec=%0d: got %b want %b", b, ec, bus.sample_valid, m_valid); else n_pass++;
            n_checks++; if (bus.sampled !== m_sampled) $display("FAIL rand_sampled b=%0d ec=%0d: got %b want %b", b, ec, bus.sampled, m_sampled); else n_pass++;
            n_checks++; if (bus.noise_err !== m_noise) $display("FAIL rand_noise b=%0d ec=%0d: got %b want %b", b, ec, bus.noise_err, m_noise); else n_pass++;
            n_checks++; if (bus.cfg_err !== m_cfg_err) $display("FAIL rand_cfg_err b=%0d ec=%0d: got %b want %b", b, ec, bus.cfg_err, m_cfg_err); else n_pass++;
            n_checks++; if (bus.rx_sync !== hist[0]) $display("FAIL rand_rx_sync b=%0d ec=%0d: got %b want %b", b, ec, bus.rx_sync, hist[0]); else n_pass++;
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_steady_3vote();
      test_5vote_noise();
      test_cfg_err();
      test_enable_drop();
      test_reset_mid();
      test_vote_sel_change();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation exceeded time limit, %0d/%0d so far", n_pass, n_checks);
      $fatal(1);
   end
endmodule

// File: doc/uart_rx_vote_sampler.md
# uart_rx_vote_sampler

Parametrised oversampling bit sampler for the UART receive path. It synchronises the raw serial input and takes a configurable odd number of majority-vote samples centred on the mid-bit point. Each bit yields one decision pulse, together with noise and configuration-error flags. It sits between the RX edge/bit counter and the deserialiser/parity/stop checkers, and supersedes the fixed 3-sample sampler.

## Interface
- `PRESCALE_W`, 6: width of `prescale` and `edge_cnt`.
- `SYNC_STAGES`, 2: flops in the input synchroniser (≥2).
- `clk` in 1: receiver oversampling clock.
- `rst` in 1: reset, asynchronous, active-high.
- `enable` in 1: sampling allowed; low forces the FSM to IDLE.
- `rx_in` in 1: raw asynchronous serial line.
- `prescale` in PRESCALE_W: oversampling ratio (clocks per bit).
- `edge_cnt` in PRESCALE_W: position within the current bit (0 to prescale−1), from the edge counter.
- `vote_sel` in 2: votes per bit: 0→1, 1→3, 2→5, 3→7.
- `rx_sync` out 1: synchronised line, shared with the start/stop detectors.
- `sampled` out 1: voted bit value, held between decisions.
- `sample_valid` out 1: one-cycle pulse when `sampled` is updated.
- `noise_err` out 1: valid with `sample_valid`; high when the votes were not unanimous.
- `cfg_err` out 1: latched configuration does not fit in the bit.

## Operation
- Synchroniser: `rx_in` passes through SYNC_STAGES flops, all reset to 1. `rx_sync` is the last stage. All votes use `rx_sync`.
- Per-bit configuration is latched whenever `edge_cnt`==0 and `enable`=1:
  - V = votes decoded from `vote_sel`.
  - h = (V−1)/2.
  - c = `prescale`>>1.
  - Window is [c−h, c+h].
  - `cfg_err` is set to (c<h) or (c+h > prescale−1).
  - `cfg_err` is held until the next latch point.
- FSM states: IDLE, WAIT, COLLECT, HOLD.
  - IDLE: transition to WAIT at `edge_cnt`==0 with `enable`=1 and a valid configuration.
  - WAIT: transition to COLLECT when `edge_cnt`==c−h. That cycle counts as the first vote.
  - COLLECT: each cycle with `edge_cnt` in the window, `ones_cnt`++ if `rx_sync`=1, and `tot_cnt`++. When `edge_cnt`==c+h, take the final vote, then decide and transition to HOLD.
  - HOLD: transition to WAIT at the next `edge_cnt`==0 (relatch), otherwise stay.
- Decision:
  - `sampled` = (ones_total > h).
  - `noise_err` = (ones_total ≠ 0 and ones_total ≠ V). The total includes the final vote.
- Counters are 3 bits wide, since the maximum count is 7. They clear on entry to WAIT.
- Abort: if `edge_cnt` returns to 0 while in WAIT or COLLECT (bit truncated), counters clear, no pulse is emitted, and the block relatches into WAIT.
- `enable`=0 in any state: transition to IDLE immediately and clear counters. No pulse is emitted. `sampled` holds its value.
- Configuration error: the block stays in IDLE. No votes, no pulse.
- Changes to `vote_sel` or `prescale` mid-bit have no effect until the next `edge_cnt`==0.

## Timing
- Reset values:
  - `sampled`=1, `rx_sync`=1.
  - `sample_valid`=0, `noise_err`=0, `cfg_err`=0.
  - FSM in IDLE, counters 0.
- `rx_in` to `rx_sync` latency: SYNC_STAGES cycles.
- `sample_valid`, `sampled` and `noise_err` are all registered. They update on the clock edge after the cycle in which `edge_cnt`==c+h. `sample_valid` is high for exactly 1 cycle.
- `noise_err` is 0 whenever `sample_valid`=0.
- `cfg_err` is registered and updates the cycle after the latch point.
- Reset mid-window: outputs return to their reset values asynchronously. No pulse follows release.

## Structure
- Package `uart_rx_pkg`:
  - vote-mode encoding constants (VOTE_1/3/5/7);
  - a function mapping `vote_sel` to V;
  - the FSM state enum.
- Sub-module `rx_sync`: SYNC_STAGES-deep, reset-to-1 synchroniser. It is instantiated once.

## Test plan
- prescale=8, vote_sel=1, line steady 1:
  - votes are taken at edge_cnt 3, 4, 5;
  - `sample_valid` pulses the cycle after edge_cnt=5;
  - `sampled`=1, `noise_err`=0.
- prescale=16, vote_sel=2, rx_sync 1,0,1,1,0 at edge_cnt 6..10:
  - `sampled`=1, `noise_err`=1.
- prescale=4, vote_sel=3:
  - `cfg_err`=1 the cycle after edge_cnt=0;
  - no `sample_valid` for the whole bit.
- prescale=8, vote_sel=1, `enable` dropped at edge_cnt=4:
  - no pulse;
  - `sampled` unchanged;
  - normal decision on the next full bit.
- `rst` asserted at edge_cnt=4 with prescale=8:
  - `sampled`=1, `sample_valid`=0, `rx_sync`=1 immediately;
  - `rx_in`=0 appears on `rx_sync` 2 cycles after release.
- `vote_sel` changed from 1 to 3 at edge_cnt=2:
  - the current bit still uses 3 votes;
  - the next bit uses 7 votes (edge_cnt 5..11 at prescale=16).
